// File: rtl/led_blinker_if.sv
// rtl/led_blinker_if.sv - event/LED status bundle between event logic and the blinker
interface led_blinker_if #(
  parameter int PW = 3
) ();
  logic          event_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;

  modport master (
    output event_in,
    input  led_out,
    input  busy,
    input  pending,
    input  dropped
  );

  modport slave (
    input  event_in,
    output led_out,
    output busy,
    output pending,
    output dropped
  );
endinterface

// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - one visible blink (ON then OFF) per single-cycle event
// Define LED_BLINK_QUEUE_EN to queue events that arrive mid-blink; otherwise they are dropped.
module led_blinker #(
  parameter int CLK_FREQ_KHZ = 50000,
  parameter int ON_TIME      = 200,
  parameter int OFF_TIME     = 200,
  parameter int MAX_PENDING  = 7
) (
  input  logic          clk,
  input  logic          rst,
  led_blinker_if.slave  bus
);
  localparam int ON_CYCLES  = ON_TIME * CLK_FREQ_KHZ;
  localparam int OFF_CYCLES = OFF_TIME * CLK_FREQ_KHZ;
  localparam int MAX_CYC    = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW         = $clog2(MAX_CYC + 1);
  localparam int PW         = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pend;
  logic          led_q;
  logic          busy_q;
  logic          drop_q;

  logic off_end;
  logic pend_nz;
  logic ev_busy;

  always_comb begin
    off_end = (state == OFF) && (cnt == '0);
    pend_nz = (pend != '0);
    // Events that neither start a blink from IDLE nor get consumed at the OFF boundary.
    ev_busy = bus.event_in && (state != IDLE) && !off_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.event_in) begin
            state  <= ON;
            cnt    <= ON_LOAD;
            led_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ON: begin
          if (cnt == '0) begin
            state <= OFF;
            cnt   <= OFF_LOAD;
            led_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OFF: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (pend_nz || bus.event_in) begin
            state <= ON;
            cnt   <= ON_LOAD;
            led_q <= 1'b1;
            // A simultaneous event replaces the queued one being popped: net pending unchanged.
            if (pend_nz && !bus.event_in) begin
              pend <= pend - 1'b1;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          led_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase

      if (ev_busy) begin
`ifdef LED_BLINK_QUEUE_EN
        if (pend != PEND_MAX) begin
          pend <= pend + 1'b1;
        end else begin
          drop_q <= 1'b1;
        end
`else
        drop_q <= 1'b1;
`endif
      end
    end
  end

`ifndef LED_BLINK_QUEUE_EN
  logic unused_pend_max;
  assign unused_pend_max = ^PEND_MAX;
`endif

  assign bus.led_out = led_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pend;
  assign bus.dropped = drop_q;
endmodule
